// File: rtl/dr_alm_arb_pkg.sv
// Shared types and helpers for the DR-ALM multiplier arbiter: operand/result
// records and the round-robin grant search.
package dr_alm_arb_pkg;

  localparam int DATA_W   = 16;
  localparam int PROD_W   = 32;
  localparam int MAX_REQ  = 8;
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic [ID_MAX_W-1:0]      id;
  } req_t;

  typedef struct packed {
    logic signed [PROD_W-1:0] z;
    logic [ID_MAX_W-1:0]      id;
  } rsp_t;

  // First valid requester strictly after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [ID_MAX_W-1:0] ptr,
                                                 input int n);
    logic [MAX_REQ-1:0] grant;
    logic [ID_MAX_W-1:0] idx;
    logic found;
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= n && !found) begin
        idx = ID_MAX_W'((int'(ptr) + k) % n);
        if (valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/dr_alm_core.sv
// Combinational DR-ALM style approximate signed multiplier: log-domain add of
// truncated mantissas; exact whenever both operand magnitudes are powers of two.
module dr_alm_core #(
  parameter int DWIDTH      = 16,
  parameter int TRUNC_WIDTH = 3
) (
  input  logic signed [DWIDTH-1:0]   i_a,
  input  logic signed [DWIDTH-1:0]   i_b,
  output logic signed [2*DWIDTH-1:0] o_z
);

  localparam int FW = DWIDTH - 1;
  localparam int KW = $clog2(DWIDTH);

  // Returns {leading-one position, fraction}; dropped bits collapse to a half-LSB
  // only when nonzero so exact powers of two stay exact.
  function automatic logic [KW+FW-1:0] log_enc(input logic [DWIDTH-1:0] mag);
    logic [KW-1:0]     k;
    logic [DWIDTH-1:0] norm;
    logic [FW-1:0]     f;
    logic              sticky;
    k = '0;
    for (int i = 0; i < DWIDTH; i++) begin
      if (mag[i]) k = KW'(i);
    end
    norm   = mag << (KW'(FW) - k);
    f      = norm[FW-1:0];
    sticky = 1'b0;
    for (int i = 0; i < TRUNC_WIDTH; i++) begin
      sticky = sticky | f[i];
      f[i]   = 1'b0;
    end
    for (int i = 0; i < TRUNC_WIDTH; i++) begin
      if (i == TRUNC_WIDTH - 1) f[i] = sticky;
    end
    return {k, f};
  endfunction

  logic [DWIDTH-1:0]   mag_a, mag_b, mant;
  logic [KW-1:0]       k_a, k_b;
  logic [FW-1:0]       f_a, f_b;
  logic [FW:0]         f_sum;
  logic [KW:0]         k_sum, expo;
  logic [2*DWIDTH-1:0] mag_p;

  always_comb begin
    mag_a      = i_a[DWIDTH-1] ? (~i_a + 1'b1) : i_a;
    mag_b      = i_b[DWIDTH-1] ? (~i_b + 1'b1) : i_b;
    {k_a, f_a} = log_enc(mag_a);
    {k_b, f_b} = log_enc(mag_b);
    f_sum      = {1'b0, f_a} + {1'b0, f_b};
    k_sum      = {1'b0, k_a} + {1'b0, k_b};
    if (f_sum[FW]) begin
      mant = f_sum;
      expo = k_sum + 1'b1;
    end else begin
      mant = {1'b1, f_sum[FW-1:0]};
      expo = k_sum;
    end
    mag_p = (2*DWIDTH)'(((3*DWIDTH)'(mant) << expo) >> FW);
    if (mag_a == '0 || mag_b == '0) begin
      o_z = '0;
    end else if (i_a[DWIDTH-1] ^ i_b[DWIDTH-1]) begin
      o_z = ~mag_p + 1'b1;
    end else begin
      o_z = mag_p;
    end
  end

endmodule

// File: rtl/dr_alm_rsp_fifo.sv
// Show-ahead result FIFO: head entry is presented straight from storage,
// push and pop may coincide at any occupancy including full.
module dr_alm_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q;
  logic             full, do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = i_pop && !o_empty;
  assign o_head  = mem_q[rd_q];
  assign o_count = count_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (i_push) begin
        mem_q[wr_q] <= i_push_data;
        wr_q        <= ptr_next(wr_q);
      end
      if (do_pop) rd_q <= ptr_next(rd_q);
      case ({i_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && full && !do_pop));

endmodule

// File: rtl/dr_alm_mult_arbiter.sv
// Round-robin, credit-gated sharing of one DR-ALM multiplier among N_REQ
// requesters, with a stall-free pipeline feeding an in-order result FIFO.
module dr_alm_mult_arbiter
  import dr_alm_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TRUNC_WIDTH = 3,
  parameter int PIPE_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  localparam int ID_W = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req_valid,
  output logic [N_REQ-1:0]          o_req_ready,
  input  logic [N_REQ*DATA_W-1:0]   i_req_a,
  input  logic [N_REQ*DATA_W-1:0]   i_req_b,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic signed [PROD_W-1:0]  o_rsp_z,
  output logic [ID_W-1:0]           o_rsp_id,
  output logic                      o_busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [CW-1:0]            credits_q, credits_d, fifo_count, pipe_occ;
  logic [ID_MAX_W-1:0]      ptr_q, acc_id;
  logic [MAX_REQ-1:0]       valid_ext, grant_ext;
  logic                     accept, pop, push, rsp_valid, fifo_empty;
  logic signed [DATA_W-1:0] acc_a, acc_b;
  logic                     s1_valid_q;
  req_t                     s1_req_q;
  logic signed [PROD_W-1:0] core_z;
  rsp_t                     core_rsp, push_data, fifo_head;
  logic [$bits(rsp_t)-1:0]  head_bits;

  // Grant looks only at registered credits and pointer, never at the consumer.
  always_comb begin
    valid_ext            = '0;
    valid_ext[N_REQ-1:0] = i_req_valid;
    grant_ext = (credits_q != '0) ? rr_pick(valid_ext, ptr_q, N_REQ) : '0;
  end

  assign o_req_ready = grant_ext[N_REQ-1:0];
  assign accept      = |(o_req_ready & i_req_valid);

  always_comb begin
    acc_id = '0;
    acc_a  = '0;
    acc_b  = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (o_req_ready[r]) begin
        acc_id = ID_MAX_W'(r);
        acc_a  = i_req_a[DATA_W*r +: DATA_W];
        acc_b  = i_req_b[DATA_W*r +: DATA_W];
      end
    end
  end

  always_comb begin
    credits_d = credits_q;
    if (accept && !pop)      credits_d = credits_q - 1'b1;
    else if (!accept && pop) credits_d = credits_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q      <= ID_MAX_W'(N_REQ - 1);
      credits_q  <= CW'(FIFO_DEPTH);
      s1_valid_q <= 1'b0;
      s1_req_q   <= '0;
    end else begin
      credits_q  <= credits_d;
      s1_valid_q <= accept;
      if (accept) begin
        ptr_q    <= acc_id;
        s1_req_q <= '{a: acc_a, b: acc_b, id: acc_id};
      end
    end
  end

  dr_alm_core #(
    .DWIDTH      (DATA_W),
    .TRUNC_WIDTH (TRUNC_WIDTH)
  ) u_core (
    .i_a (s1_req_q.a),
    .i_b (s1_req_q.b),
    .o_z (core_z)
  );

  assign core_rsp = '{z: core_z, id: s1_req_q.id};

  if (PIPE_STAGES == 1) begin : g_direct
    assign push      = s1_valid_q;
    assign push_data = core_rsp;
    assign pipe_occ  = CW'(s1_valid_q);
  end else begin : g_pipe
    logic [PIPE_STAGES-2:0] sv_q;
    rsp_t                   sd_q [PIPE_STAGES-1];

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        sv_q <= '0;
        for (int i = 0; i < PIPE_STAGES - 1; i++) sd_q[i] <= '0;
      end else begin
        sv_q[0] <= s1_valid_q;
        sd_q[0] <= core_rsp;
        for (int i = 1; i < PIPE_STAGES - 1; i++) begin
          sv_q[i] <= sv_q[i-1];
          sd_q[i] <= sd_q[i-1];
        end
      end
    end

    always_comb begin
      pipe_occ = CW'(s1_valid_q);
      for (int i = 0; i < PIPE_STAGES - 1; i++) pipe_occ = pipe_occ + CW'(sv_q[i]);
    end

    assign push      = sv_q[PIPE_STAGES-2];
    assign push_data = sd_q[PIPE_STAGES-2];
  end

  dr_alm_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(rsp_t))
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (push),
    .i_push_data (push_data),
    .i_pop       (pop),
    .o_head      (head_bits),
    .o_empty     (fifo_empty),
    .o_count     (fifo_count)
  );

  assign fifo_head   = rsp_t'(head_bits);
  assign rsp_valid   = !fifo_empty;
  assign pop         = rsp_valid && i_rsp_ready;
  assign o_rsp_valid = rsp_valid;
  assign o_rsp_z     = fifo_head.z;
  assign o_rsp_id    = fifo_head.id[ID_W-1:0];
  assign o_busy      = (credits_q != CW'(FIFO_DEPTH));

  a_credit_range: assert property (@(posedge i_clk) disable iff (i_rst)
    credits_q <= CW'(FIFO_DEPTH));
  a_no_overissue: assert property (@(posedge i_clk) disable iff (i_rst)
    !(accept && credits_q == '0));
  a_credit_sum: assert property (@(posedge i_clk) disable iff (i_rst)
    int'(credits_q) + int'(pipe_occ) + int'(fifo_count) == FIFO_DEPTH);
  a_grant_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0(grant_ext));
  a_head_id: assert property (@(posedge i_clk) disable iff (i_rst)
    !rsp_valid || int'(fifo_head.id) < N_REQ);

endmodule
